// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N ready/valid byte producers.
// Optional message lock (req_last framing) is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int N         = 4,
  parameter int DATA_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N*DATA_BITS-1:0]    req_data,
  input  logic [N-1:0]              req_valid,
  input  logic [N-1:0]              req_last,
  output logic [N-1:0]              req_ready,
  output logic [DATA_BITS-1:0]      tx_data,
  output logic                      tx_data_valid,
  input  logic                      tx_data_ready,
  output logic [$clog2(N)-1:0]      grant_id,
  output logic                      busy
);
  localparam int IDW = $clog2(N);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_reg, state_next;
  logic [DATA_BITS-1:0]  tx_data_reg;
  logic [IDW-1:0]        grant_reg;
  logic [IDW-1:0]        last_grant_reg;
  logic [DATA_BITS-1:0]  data_arr [N];
  logic [N-1:0]          eligible;
  logic [IDW-1:0]        winner;
  logic                  found;
  logic                  accept;
  logic                  locked;
  int                    idx_i;
  logic [IDW-1:0]        idx_v;

`ifdef UART_ARB_LOCK_EN
  logic                  locked_reg;
  logic                  end_reg;
  logic [IDW-1:0]        owner_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req
      assign data_arr[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
`ifdef UART_ARB_LOCK_EN
      // While a message is locked, only its owner may be picked.
      assign eligible[gi] = req_valid[gi] & (~locked_reg | (owner_reg == IDW'(gi)));
`else
      assign eligible[gi] = req_valid[gi];
`endif
      assign req_ready[gi] = accept & (winner == IDW'(gi));
    end
  endgenerate

  // Scan from the requester after the last grant, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx_i  = 0;
    idx_v  = '0;
    for (int k = 1; k <= N; k++) begin
      idx_i = (int'(last_grant_reg) + k) % N;
      idx_v = idx_i[IDW-1:0];
      if (!found && eligible[idx_v]) begin
        found  = 1'b1;
        winner = idx_v;
      end
    end
  end

  assign accept = (state_reg == IDLE) && found;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SEND;
      SEND:    if (tx_data_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      tx_data_reg <= '0;
      grant_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        tx_data_reg <= data_arr[winner];
        grant_reg   <= winner;
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  // Rotation advances only when a whole message has left the transmitter.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= IDW'(N-1);
      locked_reg     <= 1'b0;
      end_reg        <= 1'b0;
      owner_reg      <= '0;
    end else begin
      if (accept) begin
        end_reg <= req_last[winner];
        if (!req_last[winner]) begin
          locked_reg <= 1'b1;
          owner_reg  <= winner;
        end
      end
      if (state_reg == SEND && tx_data_ready && end_reg) begin
        locked_reg     <= 1'b0;
        last_grant_reg <= grant_reg;
      end
    end
  end

  assign locked = locked_reg;
`else
  logic unused_last;
  assign unused_last = ^req_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= IDW'(N-1);
    end else if (accept) begin
      last_grant_reg <= winner;
    end
  end

  assign locked = 1'b0;
`endif

  assign tx_data       = tx_data_reg;
  assign tx_data_valid = (state_reg == SEND);
  assign grant_id      = grant_reg;
  assign busy          = (state_reg == SEND) | locked;

endmodule
